// File: rtl/cv32e41s_pmr_utlb_pkg.sv
// Shared types for the PMR micro-TLB: request kinds, FSM states and the cache entry layout.
package cv32e41s_pmr_utlb_pkg;

    localparam int unsigned PMR_UTLB_MAX_ENTRIES = 16;
    localparam int unsigned PMR_UTLB_IDX_W       = 4;

    typedef enum logic [1:0] {
        EXEC  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        UTLB_IDLE   = 2'b00,
        UTLB_LOOKUP = 2'b01,
        UTLB_WALK   = 2'b10,
        UTLB_RESP   = 2'b11
    } utlb_fsm_e;

    // Tag is held zero-extended so the layout does not depend on the page size.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [33:0] delta;
        logic [2:0]  perm;
    } pmr_utlb_entry_t;

    // Permission bit for an access type, in {x, w, r} order.
    function automatic logic [2:0] perm_mask(input pmp_req_e req_type);
        logic [2:0] mask_s;
        case (req_type)
            EXEC:    mask_s = 3'b100;
            WRITE:   mask_s = 3'b010;
            READ:    mask_s = 3'b001;
            default: mask_s = 3'b000;
        endcase
        return mask_s;
    endfunction

endpackage

// File: rtl/cv32e41s_pmr_utlb_if.sv
// Core-side request/response and walker-side handshake of the PMR micro-TLB.
interface cv32e41s_pmr_utlb_if;
    import cv32e41s_pmr_utlb_pkg::*;

    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    pmp_req_e    req_type_i;
    logic        rsp_valid_o;
    logic [33:0] rsp_addr_o;
    logic        rsp_err_o;
    logic        walk_start_o;
    logic [33:0] walk_addr_o;
    pmp_req_e    walk_type_o;
    logic        walk_done_i;
    logic        walk_err_i;
    logic [33:0] walk_reloc_i;

    modport slave (
        input  flush_i, req_valid_i, req_addr_i, req_type_i,
        input  walk_done_i, walk_err_i, walk_reloc_i,
        output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_err_o,
        output walk_start_o, walk_addr_o, walk_type_o
    );

    modport master (
        output flush_i, req_valid_i, req_addr_i, req_type_i,
        output walk_done_i, walk_err_i, walk_reloc_i,
        input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_err_o,
        input  walk_start_o, walk_addr_o, walk_type_o
    );

endinterface

// File: rtl/cv32e41s_pmr_utlb_lookup.sv
// Parallel tag compare over all entries; serves both the hit check and the fill victim choice.
module cv32e41s_pmr_utlb_lookup
    import cv32e41s_pmr_utlb_pkg::*;
#(
    parameter int unsigned UTLB_ENTRIES = 4
) (
    input  pmr_utlb_entry_t            entries_i [UTLB_ENTRIES],
    input  logic [31:0]                tag_i,
    input  logic [2:0]                 perm_i,
    output logic                       hit_o,
    output logic [UTLB_ENTRIES-1:0]    hit_onehot_o,
    output logic                       match_o,
    output logic [PMR_UTLB_IDX_W-1:0]  match_idx_o,
    output logic                       inv_found_o,
    output logic [PMR_UTLB_IDX_W-1:0]  inv_idx_o
);

    // Tag match, permission hit and lowest free slot, scanned from index 0 upward
    always_comb begin
        hit_onehot_o = '0;
        match_o      = 1'b0;
        match_idx_o  = '0;
        inv_found_o  = 1'b0;
        inv_idx_o    = '0;
        for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
            if (entries_i[i].valid && (entries_i[i].tag == tag_i)) begin
                if (!match_o) begin
                    match_o     = 1'b1;
                    match_idx_o = PMR_UTLB_IDX_W'(i);
                end else begin
                    match_o     = 1'b1;
                end
                if ((entries_i[i].perm & perm_i) != 3'b000) begin
                    hit_onehot_o[i] = 1'b1;
                end else begin
                    hit_onehot_o[i] = 1'b0;
                end
            end else if (!entries_i[i].valid && !inv_found_o) begin
                inv_found_o = 1'b1;
                inv_idx_o   = PMR_UTLB_IDX_W'(i);
            end else begin
                inv_found_o = inv_found_o;
            end
        end
        hit_o = |hit_onehot_o;
    end

endmodule

// File: rtl/cv32e41s_pmr_utlb.sv
// Micro-TLB caching successful PMR walk results per page; misses are forwarded to the trie walker.
module cv32e41s_pmr_utlb
    import cv32e41s_pmr_utlb_pkg::*;
#(
    parameter int unsigned UTLB_ENTRIES = 4,
    parameter int unsigned PAGE_SHIFT   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    cv32e41s_pmr_utlb_if.slave   bus
);

    localparam int unsigned IDX_W = PMR_UTLB_IDX_W;

    utlb_fsm_e              state_r, state_s;
    logic [31:0]            addr_r;
    pmp_req_e               type_r;
    logic [33:0]            rsp_addr_r, rsp_addr_s;
    logic                   rsp_err_r, rsp_err_s;
    logic                   walk_flush_r;
    logic [IDX_W-1:0]       ptr_r;
    pmr_utlb_entry_t        entries_r [UTLB_ENTRIES];

    logic                   accept_s;
    logic                   walk_start_s;
    logic                   fill_s;
    logic [31:0]            tag_s;
    logic [2:0]             perm_s;
    logic                   hit_s;
    logic [UTLB_ENTRIES-1:0] hit_onehot_s;
    logic                   match_s;
    logic [IDX_W-1:0]       match_idx_s;
    logic                   inv_found_s;
    logic [IDX_W-1:0]       inv_idx_s;
    logic [IDX_W-1:0]       victim_s;
    logic [33:0]            hit_delta_s;
    logic [33:0]            new_delta_s;

    assign tag_s       = addr_r >> PAGE_SHIFT;
    assign perm_s      = perm_mask(type_r);
    assign new_delta_s = bus.walk_reloc_i - {2'b00, addr_r};
    assign victim_s    = inv_found_s ? inv_idx_s : ptr_r;

    cv32e41s_pmr_utlb_lookup #(.UTLB_ENTRIES(UTLB_ENTRIES)) u_lookup (
        .entries_i    (entries_r),
        .tag_i        (tag_s),
        .perm_i       (perm_s),
        .hit_o        (hit_s),
        .hit_onehot_o (hit_onehot_s),
        .match_o      (match_s),
        .match_idx_o  (match_idx_s),
        .inv_found_o  (inv_found_s),
        .inv_idx_o    (inv_idx_s)
    );

    // Delta of the hitting entry (tags are unique, so at most one bit is set)
    always_comb begin
        hit_delta_s = '0;
        for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
            if (hit_onehot_s[i]) begin
                hit_delta_s = entries_r[i].delta;
            end else begin
                hit_delta_s = hit_delta_s;
            end
        end
    end

    // Next-state, walk launch, response data and fill decision
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        walk_start_s = 1'b0;
        fill_s       = 1'b0;
        rsp_addr_s   = rsp_addr_r;
        rsp_err_s    = rsp_err_r;
        case (state_r)
            UTLB_IDLE: begin
                if (bus.req_valid_i) begin
                    accept_s = 1'b1;
                    state_s  = UTLB_LOOKUP;
                end else begin
                    state_s  = UTLB_IDLE;
                end
            end
            UTLB_LOOKUP: begin
                // A flush arriving with the lookup must not serve stale data
                if (hit_s && !bus.flush_i) begin
                    rsp_addr_s = {2'b00, addr_r} + hit_delta_s;
                    rsp_err_s  = 1'b0;
                    state_s    = UTLB_RESP;
                end else begin
                    walk_start_s = 1'b1;
                    state_s      = UTLB_WALK;
                end
            end
            UTLB_WALK: begin
                if (bus.walk_done_i || bus.walk_err_i) begin
                    rsp_err_s = bus.walk_err_i;
                    if (bus.walk_err_i) begin
                        rsp_addr_s = {2'b00, addr_r};
                    end else begin
                        rsp_addr_s = bus.walk_reloc_i;
                    end
                    fill_s  = !bus.walk_err_i && !bus.flush_i && !walk_flush_r;
                    state_s = UTLB_RESP;
                end else begin
                    state_s = UTLB_WALK;
                end
            end
            UTLB_RESP: begin
                state_s = UTLB_IDLE;
            end
            default: begin
                state_s = UTLB_IDLE;
            end
        endcase
    end

    // FSM state, latched request and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= UTLB_IDLE;
            addr_r       <= 32'h0000_0000;
            type_r       <= EXEC;
            rsp_addr_r   <= 34'h0_0000_0000;
            rsp_err_r    <= 1'b0;
            walk_flush_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rsp_addr_r <= rsp_addr_s;
            rsp_err_r  <= rsp_err_s;
            if (accept_s) begin
                addr_r       <= bus.req_addr_i;
                type_r       <= bus.req_type_i;
                walk_flush_r <= 1'b0;
            end else if ((state_r == UTLB_WALK) && bus.flush_i) begin
                walk_flush_r <= 1'b1;
            end
        end
    end

    // Entry array and replacement pointer; flush beats any concurrent fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
                entries_r[i] <= '0;
            end
            ptr_r <= '0;
        end else if (bus.flush_i) begin
            for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
                entries_r[i].valid <= 1'b0;
                entries_r[i].perm  <= 3'b000;
            end
            ptr_r <= '0;
        end else if (fill_s) begin
            if (match_s) begin
                for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
                    if (IDX_W'(i) == match_idx_s) begin
                        entries_r[i].perm <= entries_r[i].perm | perm_s;
                    end
                end
            end else begin
                for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
                    if (IDX_W'(i) == victim_s) begin
                        entries_r[i].valid <= 1'b1;
                        entries_r[i].tag   <= tag_s;
                        entries_r[i].delta <= new_delta_s;
                        entries_r[i].perm  <= perm_s;
                    end
                end
                if (!inv_found_s) begin
                    ptr_r <= (ptr_r == IDX_W'(UTLB_ENTRIES - 1)) ? '0 : ptr_r + 4'd1;
                end
            end
        end
    end

    assign bus.req_ready_o  = (state_r == UTLB_IDLE);
    assign bus.rsp_valid_o  = (state_r == UTLB_RESP);
    assign bus.rsp_addr_o   = rsp_addr_r;
    assign bus.rsp_err_o    = rsp_err_r;
    assign bus.walk_start_o = walk_start_s;
    assign bus.walk_addr_o  = {2'b00, addr_r};
    assign bus.walk_type_o  = type_r;

endmodule

// File: tb/tb_cv32e41s_pmr_utlb.sv
// Directed bench for the PMR micro-TLB: the bench plays the walker and checks responses against a page-cache model.
module tb_cv32e41s_pmr_utlb;
    import cv32e41s_pmr_utlb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cv32e41s_pmr_utlb_if bus();

    cv32e41s_pmr_utlb #(.UTLB_ENTRIES(N), .PAGE_SHIFT(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural page cache: which pages are cached, their offsets and granted access kinds
    bit          m_valid [N];
    logic [19:0] m_page  [N];
    logic [33:0] m_delta [N];
    logic [2:0]  m_perm  [N];
    int          m_ptr;

    function automatic logic [2:0] tbit(input pmp_req_e t);
        if (t == EXEC)       return 3'b100;
        else if (t == WRITE) return 3'b010;
        else                 return 3'b001;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_perm[i]  = 3'b000;
        end
        m_ptr = 0;
    endfunction

    function automatic bit model_find(input logic [31:0] a, output int idx);
        idx = 0;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_page[i] == a[31:12]) begin
                idx = i;
                return 1;
            end
        return 0;
    endfunction

    function automatic void model_fill(input logic [31:0] a, input pmp_req_e t, input logic [33:0] d);
        int idx;
        int v;
        if (model_find(a, idx)) begin
            m_perm[idx] = m_perm[idx] | tbit(t);
            return;
        end
        v = -1;
        for (int i = 0; i < N; i++)
            if (!m_valid[i] && v < 0) v = i;
        if (v < 0) begin
            v = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[v] = 1;
        m_page[v]  = a[31:12];
        m_delta[v] = d;
        m_perm[v]  = tbit(t);
    endfunction

    // Expected response shared between the driver and the compare process
    bit          exp_pending = 0;
    logic [33:0] exp_addr;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
    bit          rsp_seen;
    logic [33:0] last_addr;
    logic        last_err;

    // Compare process: every response pulse must be expected and match the model
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o) begin
            if (!exp_pending) begin
                check("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
            end else begin
                check("rsp_addr", 64'(bus.rsp_addr_o), 64'(exp_addr));
                check("rsp_err", 64'(bus.rsp_err_o), 64'(exp_err));
                check("rsp_latency", 64'(cyc - exp_acc), 64'(exp_lat));
                last_addr   = bus.rsp_addr_o;
                last_err    = bus.rsp_err_o;
                exp_pending = 0;
                rsp_seen    = 1;
            end
        end
    end

    // fmode: 0 none, 1 flush in lookup, 2 flush with walk completion, 3 flush early in walk
    task automatic do_access(input logic [31:0] a, input pmp_req_e t, input logic [33:0] reloc,
                             input logic werr, input logic wdone, input int lat, input int fmode,
                             output int starts);
        int  idx;
        bit  hit;
        bit  started;
        int  k;
        if (fmode == 1) model_flush();
        hit = model_find(a, idx) && ((m_perm[idx] & tbit(t)) != 3'b000);
        if (hit) begin
            exp_addr = {2'b00, a} + m_delta[idx];
            exp_err  = 1'b0;
            exp_lat  = 2;
        end else begin
            exp_err  = werr;
            exp_addr = werr ? {2'b00, a} : reloc;
            exp_lat  = lat + 2;
        end
        rsp_seen = 0;
        starts   = 0;
        started  = 0;
        k        = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_type_i  = t;
        exp_acc         = cyc;
        exp_pending     = 1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        if (fmode == 1) bus.flush_i = 1'b1;
        #1;
        check("busy_ready", 64'(bus.req_ready_o), 64'd0);
        if (bus.walk_start_o) begin
            starts++;
            started = 1;
            check("walk_addr", 64'(bus.walk_addr_o), 64'({2'b00, a}));
            check("walk_type", 64'(bus.walk_type_o), 64'(t));
        end
        for (int i = 0; i < 40 && !rsp_seen; i++) begin
            @(negedge clk);
            bus.flush_i     = 1'b0;
            bus.walk_done_i = 1'b0;
            bus.walk_err_i  = 1'b0;
            if (started) begin
                k++;
                if (k == lat) begin
                    if (werr) begin
                        bus.walk_err_i  = 1'b1;
                        bus.walk_done_i = wdone;
                    end else begin
                        bus.walk_done_i  = 1'b1;
                        bus.walk_reloc_i = reloc;
                    end
                    if (fmode == 2) bus.flush_i = 1'b1;
                end else if (k == 1 && fmode == 3) begin
                    bus.flush_i = 1'b1;
                end
            end
            #1;
            if (bus.walk_start_o) starts++;
        end
        bus.flush_i     = 1'b0;
        bus.walk_done_i = 1'b0;
        bus.walk_err_i  = 1'b0;
        if (!rsp_seen) begin
            check("rsp_timeout", 64'd0, 64'd1);
            exp_pending = 0;
        end
        check("walk_starts", 64'(starts), hit ? 64'd0 : 64'd1);
        if (fmode == 2 || fmode == 3) model_flush();
        else if (!hit && !werr) model_fill(a, t, reloc - {2'b00, a});
    endtask

    task automatic idle_flush();
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        model_flush();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     64'(bus.req_ready_o),  64'd1);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o),  64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err_o),    64'd0);
        check({tag, "_rsp_addr"},  64'(bus.rsp_addr_o),   64'd0);
        check({tag, "_walk_start"},64'(bus.walk_start_o), 64'd0);
        check({tag, "_walk_addr"}, 64'(bus.walk_addr_o),  64'd0);
        check({tag, "_walk_type"}, 64'(bus.walk_type_o),  64'd0);
    endtask

    initial begin
        int s;
        bus.flush_i      = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_type_i   = READ;
        bus.walk_done_i  = 1'b0;
        bus.walk_err_i   = 1'b0;
        bus.walk_reloc_i = 34'h0;
        model_flush();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Cold miss then same-page hit
        do_access(32'h0000_1234, READ, 34'h0_8000_1234, 1'b0, 1'b0, 3, 0, s);
        check("cold_starts", 64'(s), 64'd1);
        check("cold_addr", 64'(last_addr), 64'h0_8000_1234);
        check("cold_err", 64'(last_err), 64'd0);
        do_access(32'h0000_1FF0, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("hit_starts", 64'(s), 64'd0);
        check("hit_addr", 64'(last_addr), 64'h0_8000_1FF0);

        // Write to a read-only cached page walks, then gains the w bit in place
        do_access(32'h0000_1000, WRITE, 34'h0_8000_1000, 1'b0, 1'b0, 2, 0, s);
        check("wr_miss_starts", 64'(s), 64'd1);
        do_access(32'h0000_1FFC, WRITE, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("wr_hit_addr", 64'(last_addr), 64'h0_8000_1FFC);
        do_access(32'h0000_1008, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("rd_still_hit", 64'(s), 64'd0);

        // Faults: with done, then a prefix fault; never cached
        do_access(32'h0000_5000, EXEC, 34'h0, 1'b1, 1'b1, 2, 0, s);
        check("fault_err", 64'(last_err), 64'd1);
        check("fault_addr", 64'(last_addr), 64'h0_0000_5000);
        do_access(32'h0000_5000, EXEC, 34'h0, 1'b1, 1'b0, 4, 0, s);
        check("fault_rewalk", 64'(s), 64'd1);

        // Negative delta and top-of-space page, modulo 2^34
        do_access(32'h0003_0000, READ, 34'h0_0000_2000, 1'b0, 1'b0, 1, 0, s);
        do_access(32'h0003_0ABC, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("neg_delta", 64'(last_addr), 64'h0_0000_2ABC);
        do_access(32'hFFFF_F010, READ, 34'h2_0000_0010, 1'b0, 1'b0, 2, 0, s);
        do_access(32'hFFFF_FFFF, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("top_page", 64'(last_addr), 64'h2_0000_0FFF);

        // Round-robin eviction after filling all entries
        idle_flush();
        for (int p = 0; p < 5; p++)
            do_access(32'h0001_0000 + 32'(p) * 32'h1000, READ,
                      34'h1_0001_0000 + 34'(p) * 34'h1000, 1'b0, 1'b0, 1, 0, s);
        do_access(32'h0001_1004, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("evict_second_hits", 64'(s), 64'd0);
        do_access(32'h0001_0004, READ, 34'h1_0001_0004, 1'b0, 1'b0, 1, 0, s);
        check("evict_first_miss", 64'(s), 64'd1);

        // Flush during a walk: response delivered, nothing cached
        do_access(32'h0002_0000, READ, 34'h0_4002_0000, 1'b0, 1'b0, 3, 3, s);
        check("flush_walk_addr", 64'(last_addr), 64'h0_4002_0000);
        do_access(32'h0002_0010, READ, 34'h0_4002_0010, 1'b0, 1'b0, 1, 0, s);
        check("flush_walk_remiss", 64'(s), 64'd1);
        do_access(32'h0002_1000, READ, 34'h0_4002_1000, 1'b0, 1'b0, 2, 2, s);
        do_access(32'h0002_1000, READ, 34'h0_4002_1000, 1'b0, 1'b0, 1, 0, s);
        check("flush_done_remiss", 64'(s), 64'd1);

        // Flush in lookup forces a miss on a cached page
        do_access(32'h0002_1040, READ, 34'h0, 1'b0, 1'b0, 1, 0, s);
        check("pre_lookup_flush_hit", 64'(s), 64'd0);
        do_access(32'h0002_1040, READ, 34'h0_4002_1040, 1'b0, 1'b0, 1, 1, s);
        check("lookup_flush_miss", 64'(s), 64'd1);

        // Reset mid-walk, then a stale completion must be ignored
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_7000;
        bus.req_type_i  = READ;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midwalk");
        exp_pending = 0;
        model_flush();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.walk_done_i  = 1'b1;
        bus.walk_reloc_i = 34'h3_0000_7000;
        @(negedge clk);
        bus.walk_done_i = 1'b0;
        #1;
        check("late_done_ignored", 64'(bus.rsp_valid_o), 64'd0);
        check("late_done_ready", 64'(bus.req_ready_o), 64'd1);
        do_access(32'h0000_7000, READ, 34'h0_9000_7000, 1'b0, 1'b0, 2, 0, s);
        check("post_reset_miss", 64'(s), 64'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
